// File: rtl/display_pkg.sv
// Shared types for the digit scan driver.
//   bcd_digit_t  : one BCD digit (4 bits), BLANK_CODE marks a dark digit
//   scan_state_t : scan FSM states (frame clear, digit show, digit step)
//   add3         : shift-add-3 correction applied to one digit before a shift
package display_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        S_CLR  = 2'd0,
        S_SHOW = 2'd1,
        S_STEP = 2'd2
    } scan_state_t;

    localparam bcd_digit_t BLANK_CODE = 4'hF;

    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   start, value : start pulse (accepted only when idle) and value to convert
//   busy         : high for 1 load cycle plus VAL_W shift cycles
//   done         : one-cycle pulse; digits valid from then until the next start
//   digits       : NUM_DIGITS BCD digits, digit 0 least significant
// Values above 10^NUM_DIGITS-1 keep only the low NUM_DIGITS digits: carries
// out of the top digit are simply dropped, lower digits are unaffected.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int VAL_W      = 32,
    parameter int NUM_DIGITS = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [VAL_W-1:0]                 value,
    output logic                             busy,
    output logic                             done,
    output bcd_digit_t [NUM_DIGITS-1:0]      digits
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]            sr;
    bcd_digit_t [NUM_DIGITS-1:0] bcd;
    logic [4*NUM_DIGITS-2:0]     adj;
    logic [4*NUM_DIGITS-1:0]     shifted;
    logic [CNT_W-1:0]            cnt;
    logic                        load;

    // The top digit keeps only 3 corrected bits: its MSB would shift out of
    // the register anyway.
    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS - 1; i++)
            adj[4*i +: 4] = add3(bcd[i]);
        adj[4*(NUM_DIGITS-1) +: 3] = (bcd[NUM_DIGITS-1] >= 4'd5)
                                   ? bcd[NUM_DIGITS-1][2:0] + 3'd3
                                   : bcd[NUM_DIGITS-1][2:0];
        shifted = {adj, sr[VAL_W-1]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            load <= 1'b0;
            cnt  <= '0;
            sr   <= '0;
            bcd  <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    load <= 1'b1;
                    sr   <= value;
                end
            end else if (load) begin
                load <= 1'b0;
                bcd  <= '0;
                cnt  <= CNT_W'(VAL_W);
            end else begin
                bcd <= shifted;
                sr  <= {sr[VAL_W-2:0], 1'b0};
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign digits = bcd;

endmodule

// File: rtl/digit_scan_driver.sv
// Multiplexed decimal display driver: converts balance to BCD in the
// background and scans the digits out to an external digit-select counter.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   balance   : unsigned value to display
//   cclr_neg  : active-low clear of the external digit counter (frame start)
//   dclk      : one-cycle advance strobe of the external digit counter
//   num       : BCD code of the selected digit (4'hF = blank)
//   conv_busy : conversion in progress
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero digit (digit 0 always shown).
module digit_scan_driver
    import display_pkg::*;
#(
    parameter int VAL_W      = 32,
    parameter int NUM_DIGITS = 10,
    parameter int SCAN_DIV   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] balance,
    output logic             cclr_neg,
    output logic             dclk,
    output logic [3:0]       num,
    output logic             conv_busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);

    scan_state_t                 state, state_nxt;
    logic [IDX_W-1:0]            idx, idx_nxt;
    logic [DIV_W-1:0]            div_cnt, div_nxt;
    logic [VAL_W-1:0]            captured;
    logic                        start, done;
    bcd_digit_t [NUM_DIGITS-1:0] digits, result, disp;

    // A change seen while converting is picked up by this compare as soon
    // as busy drops.
    assign start = !conv_busy && (balance != captured);

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (balance),
        .busy   (conv_busy),
        .done   (done),
        .digits (digits)
    );

    // Finished digits wait in result; disp only changes at frame start so a
    // frame never mixes two values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            captured <= '0;
            result   <= '0;
            disp     <= '0;
        end else begin
            if (start)
                captured <= balance;
            if (done)
                result <= digits;
            if (state == S_CLR)
                disp <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_CLR;
            idx     <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            div_cnt <= div_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        div_nxt   = div_cnt;
        cclr_neg  = 1'b1;
        dclk      = 1'b0;
        case (state)
            S_CLR: begin
                cclr_neg  = 1'b0;
                idx_nxt   = '0;
                div_nxt   = '0;
                state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                    div_nxt   = '0;
                    state_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? S_CLR : S_STEP;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            S_STEP: begin
                dclk      = 1'b1;
                idx_nxt   = idx + 1'b1;
                state_nxt = S_SHOW;
            end
            default: state_nxt = S_CLR;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Highest nonzero digit; stays 0 for value 0 so digit 0 always shows.
    always_comb begin
        msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (disp[i] != 4'd0)
                msd = IDX_W'(i);
    end

    assign num = (idx > msd) ? BLANK_CODE : disp[idx];
`else
    assign num = disp[idx];
`endif

endmodule

// File: tb/tb_digit_scan_driver.sv
module tb_digit_scan_driver;

    localparam int VAL_W = 16;
    localparam int ND    = 5;
    localparam int SD    = 20;
    localparam int FRAME = ND * SD + (ND - 1) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] balance = '0;
    logic        cclr_neg, dclk, conv_busy;
    logic [3:0]  num;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    int busy_run = 0;

    typedef logic [ND-1:0][3:0] frame_t;
    typedef struct {
        logic [15:0] bal;
        frame_t      exp;
    } vec_t;

    digit_scan_driver #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .balance   (balance),
        .cclr_neg  (cclr_neg),
        .dclk      (dclk),
        .num       (num),
        .conv_busy (conv_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: digit d of v in decimal, with optional leading-zero blanking.
    function automatic logic [3:0] model_dig(input int v, input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p *= 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p) return 4'hF;
`endif
        return 4'((v / p) % 10);
    endfunction

    function automatic frame_t model_frame(input int v);
        frame_t f;
        for (int d = 0; d < ND; d++) f[d] = model_dig(v, d);
        return f;
    endfunction

    task automatic check_frame(input string tag, input frame_t got, input frame_t exp);
        for (int d = 0; d < ND; d++)
            cmp($sformatf("%s_digit%0d", tag, d), int'(got[d]), int'(exp[d]));
    endtask

    // Monitor: strobe overlap and length of every completed conversion.
    always @(negedge clk) begin
        if (!rst) begin
            busy_run = 0;
        end else begin
            if (!cclr_neg && dclk) overlap_cnt++;
            if (conv_busy) busy_run++;
            else if (busy_run != 0) begin
                cmp("conv_busy_len", busy_run, VAL_W + 1);
                busy_run = 0;
            end
        end
    end

    task automatic wait_clr(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cclr_neg !== 1'b0 && n < 3 * FRAME);
        cmp({tag, "_clr_seen"}, int'(cclr_neg), 0);
    endtask

    // Called at the negedge where CLR is visible; returns at the next CLR.
    task automatic capture_frame(input string tag, input int chg_at,
                                 input logic [15:0] chg_val, output frame_t digs);
        int bad_dclk = 0;
        int bad_clr  = 0;
        int bad_num  = 0;
        digs = '0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == chg_at) balance = chg_val;
            if (k == FRAME) begin
                cmp({tag, "_frame_len"}, int'(cclr_neg), 0);
            end else begin
                if (!cclr_neg) bad_clr++;
                if (dclk !== (k % (SD + 1) == 0)) bad_dclk++;
                if (k % (SD + 1) != 0) begin
                    int d;
                    d = k / (SD + 1);
                    if (k % (SD + 1) == 1) digs[d] = num;
                    else if (num !== digs[d]) bad_num++;
                end else if (num !== digs[k / (SD + 1) - 1]) begin
                    bad_num++;
                end
            end
        end
        cmp({tag, "_dclk_pattern"}, bad_dclk, 0);
        cmp({tag, "_cclr_pattern"}, bad_clr, 0);
        cmp({tag, "_num_stable"}, bad_num, 0);
    endtask

    initial begin
        vec_t        tbl[6];
        frame_t      got;
        logic [15:0] hist[$];
        logic [15:0] prev;
        int          found;

        tbl[0] = '{16'd42, `ifdef LEADING_ZERO_BLANK_EN 20'hFFF42 `else 20'h00042 `endif};
        tbl[1] = '{16'd0,  `ifdef LEADING_ZERO_BLANK_EN 20'hFFFF0 `else 20'h00000 `endif};
        tbl[2] = '{16'd65535, 20'h65535};
        tbl[3] = '{16'd10000, 20'h10000};
        tbl[4] = '{16'd12345, 20'h12345};
        tbl[5] = '{16'd60789, 20'h60789};

        // Reset held for 2 cycles with a nonzero balance waiting.
        balance = 16'd12345;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cmp("rst_cclr_neg", int'(cclr_neg), 0);
        cmp("rst_dclk", int'(dclk), 0);
        cmp("rst_num", int'(num), 0);
        cmp("rst_conv_busy", int'(conv_busy), 0);
        rst = 1'b1;

        // First frame is the CLR held by reset; display still cleared.
        capture_frame("first", 0, 16'd0, got);
        check_frame("first", got, model_frame(0));
        capture_frame("f12345", 0, 16'd0, got);
        check_frame("f12345", got, 20'h12345);

        // Change mid-frame: current frame untouched, next one updated.
        capture_frame("midchg_a", 30, 16'd60789, got);
        check_frame("midchg_a", got, 20'h12345);
        capture_frame("midchg_b", 0, 16'd0, got);
        check_frame("midchg_b", got, 20'h60789);

        for (int i = 0; i < 6; i++) begin
            balance = tbl[i].bal;
            repeat (SD) @(negedge clk);
            wait_clr($sformatf("tbl%0d", i));
            capture_frame($sformatf("tbl%0d", i), 0, 16'd0, got);
            check_frame($sformatf("tbl%0d", i), got, tbl[i].exp);
        end

        prev = balance;
        for (int i = 0; i < 4; i++) begin
            balance = 16'($urandom_range(0, 65535));
            repeat (SD) @(negedge clk);
            wait_clr($sformatf("rnd%0d", i));
            capture_frame($sformatf("rnd%0d", i), 0, 16'd0, got);
            check_frame($sformatf("rnd%0d", i), got, model_frame(int'(balance)));
            prev = balance;
        end

        // Balance toggles every 3 cycles, then settles at 65535.
        wait_clr("tog");
        hist.push_back(prev);
        fork
            capture_frame("tog_a", 0, 16'd0, got);
            begin
                for (int i = 0; i < 17; i++) begin
                    balance = 16'($urandom);
                    hist.push_back(balance);
                    repeat (3) @(negedge clk);
                end
                balance = 16'd65535;
                hist.push_back(balance);
            end
        join
        check_frame("tog_a", got, model_frame(int'(prev)));
        capture_frame("tog_b", 0, 16'd0, got);
        found = 0;
        foreach (hist[j]) if (model_frame(int'(hist[j])) == got) found = 1;
        cmp("tog_b_untorn", found, 1);
        capture_frame("tog_c", 0, 16'd0, got);
        check_frame("tog_c", got, 20'h65535);

        // Reset during SHOW(2) with a conversion running.
        wait_clr("rstmid");
        repeat (40) @(negedge clk);
        balance = 16'd1234;
        repeat (5) @(negedge clk);
        cmp("rstmid_busy_before", int'(conv_busy), 1);
        rst = 1'b0;
        @(negedge clk);
        cmp("rstmid_cclr_neg", int'(cclr_neg), 0);
        cmp("rstmid_dclk", int'(dclk), 0);
        cmp("rstmid_num", int'(num), 0);
        cmp("rstmid_conv_busy", int'(conv_busy), 0);
        rst = 1'b1;
        capture_frame("postrst_a", 0, 16'd0, got);
        check_frame("postrst_a", got, model_frame(0));
        capture_frame("postrst_b", 0, 16'd0, got);
        check_frame("postrst_b", got, model_frame(1234));

        cmp("strobe_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
